// File: rtl/color_palette_multi_if.sv
// Bus bundle for color_palette_multi: Avalon-MM slave port plus the pixel stream
// and frame strobe. The DUT uses the slave modport, the driver side uses master.
interface color_palette_multi_if #(
    parameter int NUM_PAL = 8,
    parameter int IDX_W   = 2
);
    localparam int PAL_W  = $clog2(NUM_PAL);
    localparam int ADDR_W = PAL_W + IDX_W + 1;

    logic              avl_cs;
    logic              avl_read;
    logic              avl_write;
    logic [ADDR_W-1:0] avl_addr;
    logic [3:0]        avl_byte_en;
    logic [31:0]       avl_writedata;
    logic [31:0]       avl_readdata;

    logic              pix_valid;
    logic [PAL_W-1:0]  pix_palette;
    logic [IDX_W-1:0]  pix_index;
    logic              frame_start;

    logic              rgb_valid;
    logic [23:0]       rgb;
    logic              commit_pending;

    modport slave (
        input  avl_cs, avl_read, avl_write, avl_addr, avl_byte_en, avl_writedata,
        input  pix_valid, pix_palette, pix_index, frame_start,
        output avl_readdata, rgb_valid, rgb, commit_pending
    );

    modport master (
        output avl_cs, avl_read, avl_write, avl_addr, avl_byte_en, avl_writedata,
        output pix_valid, pix_palette, pix_index, frame_start,
        input  avl_readdata, rgb_valid, rgb, commit_pending
    );
endinterface

// File: rtl/color_palette_multi.sv
// Multi-palette RGB colour LUT with a 2-stage pixel pipeline and Avalon-MM programming.
// Define PALETTE_SHADOW_EN to add a shadow table committed to the active table at FRAME_START.
module color_palette_multi #(
    parameter int NUM_PAL = 8,
    parameter int IDX_W   = 2
) (
    input logic                  clk,
    input logic                  reset,
    color_palette_multi_if.slave bus
);
    localparam int PAL_W  = $clog2(NUM_PAL);
    localparam int ADDR_W = PAL_W + IDX_W + 1;
    localparam int ENT_W  = PAL_W + IDX_W;
    localparam int DEPTH  = 1 << ENT_W;
    localparam logic [ENT_W-1:0] CTRL_OFS = ENT_W'(0);
    localparam logic [ENT_W-1:0] FCNT_OFS = ENT_W'(1);

    function automatic logic [23:0] merge_entry(input logic [23:0] old,
                                                input logic [23:0] data,
                                                input logic [2:0]  be);
        merge_entry = old;
        if (be[0]) merge_entry[7:0]   = data[7:0];
        if (be[1]) merge_entry[15:8]  = data[15:8];
        if (be[2]) merge_entry[23:16] = data[23:16];
    endfunction

    logic             wr_en;
    logic             rd_en;
    logic             is_ctrl;
    logic [ENT_W-1:0] ent_addr;
    logic             entry_wr;
    logic [23:0]      active [DEPTH];
    logic [23:0]      entry_view;
    logic             commit_pending;
    logic [15:0]      frame_cnt;
    logic [31:0]      rd_value;
    logic [31:0]      readdata;

    logic             vld_p1;
    logic [PAL_W-1:0] pal_p1;
    logic [IDX_W-1:0] idx_p1;
    logic             vld_p2;
    logic [23:0]      rgb_p2;

    assign wr_en    = bus.avl_cs & bus.avl_write;
    assign rd_en    = bus.avl_cs & bus.avl_read;
    assign is_ctrl  = bus.avl_addr[ADDR_W-1];
    assign ent_addr = bus.avl_addr[ENT_W-1:0];
    assign entry_wr = wr_en & ~is_ctrl;

    logic unused_bits;
    assign unused_bits = ^{bus.avl_writedata[31:24], bus.avl_byte_en[3]};

`ifdef PALETTE_SHADOW_EN
    logic [23:0] shadow [DEPTH];
    logic        commit_req;
    logic        do_commit;

    assign commit_req = wr_en & is_ctrl & (ent_addr == CTRL_OFS)
                      & bus.avl_byte_en[0] & bus.avl_writedata[0];
    // A request arriving on the FRAME_START edge is honoured in that same edge.
    assign do_commit  = bus.frame_start & (commit_pending | commit_req);
    assign entry_view = shadow[ent_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            commit_pending <= 1'b0;
        end else begin
            if (entry_wr)
                shadow[ent_addr] <= merge_entry(shadow[ent_addr],
                                                bus.avl_writedata[23:0],
                                                bus.avl_byte_en[2:0]);
            // Copies the pre-write shadow; a same-edge shadow write waits for the next commit.
            if (do_commit) begin
                for (int i = 0; i < DEPTH; i++)
                    active[i] <= shadow[i];
                commit_pending <= 1'b0;
            end else if (commit_req) begin
                commit_pending <= 1'b1;
            end
        end
    end
`else
    assign commit_pending = 1'b0;
    assign entry_view     = active[ent_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                active[i] <= '0;
        end else if (entry_wr) begin
            active[ent_addr] <= merge_entry(active[ent_addr],
                                            bus.avl_writedata[23:0],
                                            bus.avl_byte_en[2:0]);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_cnt <= '0;
        else if (bus.frame_start)
            frame_cnt <= frame_cnt + 16'd1;
    end

    always_comb begin
        rd_value = '0;
        if (!is_ctrl)
            rd_value = {8'h00, entry_view};
        else if (ent_addr == CTRL_OFS)
            rd_value = {31'b0, commit_pending};
        else if (ent_addr == FCNT_OFS)
            rd_value = {16'h0000, frame_cnt};
    end

    // Read data is captured from pre-edge state, so a simultaneous write is not seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            readdata <= '0;
        else if (rd_en)
            readdata <= rd_value;
    end

    // Stage 1: register the pixel request
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= bus.pix_valid;
    end

    always_ff @(posedge clk) begin
        pal_p1 <= bus.pix_palette;
        idx_p1 <= bus.pix_index;
    end

    // Stage 2: active table lookup; RGB holds across invalid slots
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2 <= 1'b0;
            rgb_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1)
                rgb_p2 <= active[{pal_p1, idx_p1}];
        end
    end

    assign bus.avl_readdata   = readdata;
    assign bus.rgb_valid      = vld_p2;
    assign bus.rgb            = rgb_p2;
    assign bus.commit_pending = commit_pending;

endmodule

// File: doc/color_palette_multi.md
# color_palette_multi

Parametrised, optionally double-buffered colour look-up table sitting between the pixel/tile fetch stage and the VGA output stage. It holds NUM_PAL palettes of 2^IDX_W 24-bit RGB entries, programmed over an Avalon-MM slave, and converts a stream of (palette, index) pixels into RGB with a fixed two-cycle pipeline. With shadowing compiled in, CPU writes land in a shadow table that is committed to the active table only at a frame boundary, so palette updates never tear mid-frame.

## Interface
- NUM_PAL, 8: number of palettes; power of two, 2..16.
- IDX_W, 2: colour-index width; 2^IDX_W entries per palette, 1..4.
- PAL_W, $clog2(NUM_PAL): palette-select width (derived).
- ADDR_W, PAL_W+IDX_W+1: Avalon word-address width (derived).
- CLK  in  1  single clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- AVL_CS  in  1  slave chip select.
- AVL_READ  in  1  read strobe, qualified by AVL_CS.
- AVL_WRITE  in  1  write strobe, qualified by AVL_CS.
- AVL_ADDR  in  ADDR_W  word address.
- AVL_BYTE_EN  in  4  byte enables.
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  read data, registered.
- PIX_VALID  in  1  pixel request valid.
- PIX_PALETTE  in  PAL_W  palette select.
- PIX_INDEX  in  IDX_W  colour index.
- FRAME_START  in  1  one-cycle strobe at start of vertical blank.
- RGB_VALID  out  1  RGB output valid.
- RGB  out  24  {R[23:16], G[15:8], B[7:0]}.
- COMMIT_PENDING  out  1  commit requested, not yet applied.

## Operation
- Address map: AVL_ADDR[ADDR_W-1]=0 -> entry {palette, index} = AVL_ADDR[ADDR_W-2:0]. AVL_ADDR[ADDR_W-1]=1 -> control space; low bits 0 = CTRL, 1 = FRAME_CNT, others read 0 and ignore writes.
- Entry write: bytes 0..2 update B, G, R independently per AVL_BYTE_EN; byte 3 ignored. Entry read returns {8'h00, entry}; with shadowing, the shadow entry (last written value) is returned.
- CTRL write with byte 0 enabled and bit0=1 sets commit_pending; bit0=0 no effect. CTRL read = {31'b0, commit_pending}.
- FRAME_CNT: 16-bit counter incremented on every FRAME_START, wraps 16'hFFFF -> 0; read-only, zero-extended.
- Commit: on FRAME_START with commit_pending=1, every active entry <= shadow entry in that cycle and commit_pending clears. FRAME_START with pending=0 changes nothing but FRAME_CNT.
- Pixel pipeline: stage 1 registers PIX_VALID/PIX_PALETTE/PIX_INDEX; stage 2 reads the active table and registers RGB, RGB_VALID. Invalid pixels propagate RGB_VALID=0 and RGB holds its previous value. No back-pressure; one pixel accepted per cycle.
- Reset: all entries (active and shadow) 0, RGB 24'h0, RGB_VALID 0, AVL_READDATA 0, commit_pending 0, FRAME_CNT 0, pipeline valids 0. Reset mid-frame discards in-flight pixels and any pending commit.

## Timing
- Avalon write: takes effect at the edge where AVL_CS & AVL_WRITE is sampled; zero wait states.
- Avalon read: AVL_READDATA valid the cycle after AVL_CS & AVL_READ; holds until the next read. Read and write asserted together: write performed, read returns pre-write value.
- Pixel latency: exactly 2 cycles, PIX_VALID at edge n -> RGB_VALID at edge n+2.
- Table sampled by stage 2 reflects all writes/commits completed at prior edges; same-edge write or commit is not visible (read-before-write).
- Commit request and FRAME_START at the same edge: commit applies at that edge. Shadow write at the commit edge: active receives pre-write shadow; new value stays in shadow, pending not re-set.
- COMMIT_PENDING equals the internal flag, updated at the edge.

## Configuration
- PALETTE_SHADOW_EN defined: shadow table present; writes target shadow; commit at FRAME_START as above.
- Undefined: single table; writes update the active table directly (visible to stage 2 next edge); CTRL bit0 writes ignored, COMMIT_PENDING tied 0, CTRL reads 0. FRAME_CNT still present.

## Test plan
- Reset, then read entry 0 and CTRL -> AVL_READDATA 32'h0, RGB_VALID 0, COMMIT_PENDING 0.
- Write palette 2 index 1 = 32'hAAFF8040 with AVL_BYTE_EN 4'hF, then write 32'h00000011 with AVL_BYTE_EN 4'h1 -> read returns 32'h00FF8011.
- Shadow: write palette 0 index 3 = 24'h123456, request commit, stream pixel (0,3) -> RGB 0 until FRAME_START; after it, pixel (0,3) gives 24'h123456 two cycles after PIX_VALID, COMMIT_PENDING drops.
- Without PALETTE_SHADOW_EN: same write, pixel (0,3) one cycle later -> RGB 24'h123456 with 2-cycle latency, no FRAME_START needed.
- Back-to-back pixels indices 0..3 of palette 0 on consecutive cycles with one PIX_VALID=0 gap -> RGB sequence matches table with RGB_VALID mirroring input delayed 2.
- Commit request plus shadow write on the FRAME_START edge -> active gets old shadow value, new value appears after the next commit; 65536 FRAME_START pulses wrap FRAME_CNT to 0.
